// File: rtl/exp4_unidade_controle.sv
// exp4_unidade_controle: Moore FSM that sequences one memory-game round; define UC_TIMEOUT_EN for the inactivity timeout
module exp4_unidade_controle #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERROU   = 4'hE
    } estado_t;

    estado_t r_estado;
    estado_t w_proximo;

`ifdef UC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] r_timer;
    logic          w_expirou;
    assign w_expirou = r_timer == TW'(TIMEOUT_CYCLES - 1);
`endif

    assign db_estado = r_estado;

    // next-state decode; a play beats an expiring timer, unused codes fall back to inicial
    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL:     w_proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  w_proximo = ESPERA;
`ifdef UC_TIMEOUT_EN
            ESPERA:      w_proximo = jogada ? REGISTRA : w_expirou ? FIM_TIMEOUT : ESPERA;
            FIM_TIMEOUT: w_proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
`else
            ESPERA:      w_proximo = jogada ? REGISTRA : ESPERA;
`endif
            REGISTRA:    w_proximo = COMPARACAO;
            COMPARACAO:  w_proximo = !igual ? FIM_ERROU : fimC ? FIM_ACERTOU : PROXIMO;
            PROXIMO:     w_proximo = ESPERA;
            FIM_ACERTOU: w_proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:   w_proximo = iniciar ? PREPARACAO : FIM_ERROU;
            default:     w_proximo = INICIAL;
        endcase
    end

    // state register with outputs registered from the next state, so they track the state exactly
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado  <= INICIAL;
            zeraC     <= 1'b0;
            zeraR     <= 1'b0;
            contaC    <= 1'b0;
            registraR <= 1'b0;
            pronto    <= 1'b0;
            acertou   <= 1'b0;
            errou     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            r_estado  <= w_proximo;
            zeraC     <= w_proximo == PREPARACAO;
            zeraR     <= w_proximo == PREPARACAO;
            contaC    <= w_proximo == PROXIMO;
            registraR <= w_proximo == REGISTRA;
            pronto    <= w_proximo == FIM_ACERTOU || w_proximo == FIM_ERROU || w_proximo == FIM_TIMEOUT;
            acertou   <= w_proximo == FIM_ACERTOU;
            errou     <= w_proximo == FIM_ERROU;
`ifdef UC_TIMEOUT_EN
            timeout   <= w_proximo == FIM_TIMEOUT;
`else
            timeout   <= 1'b0;
`endif
        end
    end

`ifdef UC_TIMEOUT_EN
    // inactivity timer: counts cycles spent in espera_jogada, restarts on every entry
    always_ff @(posedge clock) begin
        r_timer <= (!reset && r_estado == ESPERA && w_proximo == ESPERA) ? r_timer + 1'b1 : '0;
    end
`endif
endmodule
